// File: rtl/io_write_arbiter_if.sv
// Bundle between the I/O write arbiter, its requesters and the status
// register write port. The arbiter takes the master view.
interface io_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            Req_Valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] Req_WrData;
    logic [NUM_REQ*DATA_WIDTH-1:0] Req_WrMask;
    logic [NUM_REQ-1:0]            Req_Ack;
    logic [DATA_WIDTH-1:0]         IO_WrData;
    logic [DATA_WIDTH-1:0]         IO_WrMask;
    logic                          IO_WrEn;
    logic                          IO_Busy;
    logic [GW-1:0]                 Grant_Id;
    logic                          Timeout_Err;

    modport master (
        input  Req_Valid, Req_WrData, Req_WrMask, IO_Busy,
        output Req_Ack, IO_WrData, IO_WrMask, IO_WrEn, Grant_Id, Timeout_Err
    );

    modport slave (
        output Req_Valid, Req_WrData, Req_WrMask, IO_Busy,
        input  Req_Ack, IO_WrData, IO_WrMask, IO_WrEn, Grant_Id, Timeout_Err
    );
endinterface

// File: rtl/io_write_arbiter.sv
// Round-robin arbiter sharing one status-register write port among NUM_REQ
// requesters. Issues one masked write, follows the register's Busy crossing
// handshake to completion, then acknowledges the winner. A write whose Busy
// never rises is dropped after BUSY_TIMEOUT cycles and flagged sticky.
module io_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic               Clock,
    input  logic               Reset,
    io_write_arbiter_if.master bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        ACK       = 3'd4
    } state_t;

    state_t                state_q;
    logic [GW-1:0]         ptr_q;
    logic [GW-1:0]         grant_q;
    logic [TW-1:0]         timer_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] wr_mask_q;
    logic                  wr_en_q;
    logic                  timeout_q;
    logic [NUM_REQ-1:0]    ack_q;

    logic                  any_d;
    logic [GW-1:0]         pick_d;
    logic [GW-1:0]         scan_idx;
    logic [DATA_WIDTH-1:0] pick_data_d;
    logic [DATA_WIDTH-1:0] pick_mask_d;
    logic [GW-1:0]         ptr_d;
    logic [TW-1:0]         timer_d;

    // Round-robin pick: scan from the pointer upward with wrap; the lowest
    // offset that is requesting wins, so the loop runs from the far end down.
    always_comb begin
        any_d    = 1'b0;
        pick_d   = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = GW'((int'(ptr_q) + k) % NUM_REQ);
            if (bus.Req_Valid[scan_idx]) begin
                any_d  = 1'b1;
                pick_d = scan_idx;
            end
        end
        pick_data_d = bus.Req_WrData[int'(pick_d) * DATA_WIDTH +: DATA_WIDTH];
        pick_mask_d = bus.Req_WrMask[int'(pick_d) * DATA_WIDTH +: DATA_WIDTH];
    end

    // Next pointer sits just past the requester being acknowledged; timer step.
    always_comb begin
        ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        timer_d = timer_q + 1'b1;
    end

    // Transaction FSM; every output is a register set on the transition
    // into the state where it must be visible.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            timer_q   <= '0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
            wr_en_q   <= 1'b0;
            timeout_q <= 1'b0;
            ack_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            ack_q   <= '0;
            case (state_q)
                IDLE: begin
                    // A pending crossing blocks new issues.
                    if (any_d && !bus.IO_Busy) begin
                        wr_data_q <= pick_data_d;
                        wr_mask_q <= pick_mask_d;
                        grant_q   <= pick_d;
                        wr_en_q   <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= bus.IO_Busy ? WAIT_FALL : WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (bus.IO_Busy) begin
                        state_q <= WAIT_FALL;
                    end else begin
                        timer_q <= timer_d;
                        if (timer_d == TW'(BUSY_TIMEOUT)) begin
                            // Busy never rose: drop the write but still release the requester.
                            timeout_q <= 1'b1;
                            ack_q     <= NUM_REQ'(1) << grant_q;
                            state_q   <= ACK;
                        end
                    end
                end
                WAIT_FALL: begin
                    if (!bus.IO_Busy) begin
                        ack_q   <= NUM_REQ'(1) << grant_q;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.IO_WrEn     = wr_en_q;
    assign bus.IO_WrData   = wr_data_q;
    assign bus.IO_WrMask   = wr_mask_q;
    assign bus.Req_Ack     = ack_q;
    assign bus.Grant_Id    = grant_q;
    assign bus.Timeout_Err = timeout_q;
endmodule

// File: tb/tb_io_write_arbiter.sv
// Bench for io_write_arbiter: table of single-requester transactions,
// hand-written multi-cycle sequences, then a randomized run against a
// transaction-level round-robin model.
module tb_io_write_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TO = 15;

    logic Clock = 1'b0;
    logic Reset;

    io_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus();

    io_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUSY_TIMEOUT(TO)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int               tests = 0;
    int               fails = 0;
    int               cyc   = 0;
    logic [NR-1:0]    req_v;
    logic [DW-1:0]    rdata [NR];
    logic [DW-1:0]    rmask [NR];
    logic             busy;

    assign bus.Req_Valid  = req_v;
    assign bus.Req_WrData = {rdata[3], rdata[2], rdata[1], rdata[0]};
    assign bus.Req_WrMask = {rmask[3], rmask[2], rmask[1], rmask[0]};
    assign bus.IO_Busy    = busy;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic [31:0] mask;
        int          d;
        int          h;
        int          exp_gid;
        int          exp_lat;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, ".wren"}, 64'(bus.IO_WrEn), 64'd0);
        chk({nm, ".ack"}, 64'(bus.Req_Ack), 64'd0);
        chk({nm, ".gid"}, 64'(bus.Grant_Id), 64'd0);
        chk({nm, ".terr"}, 64'(bus.Timeout_Err), 64'd0);
        chk({nm, ".wdata"}, 64'(bus.IO_WrData), 64'd0);
        chk({nm, ".wmask"}, 64'(bus.IO_WrMask), 64'd0);
    endtask

    // Waits for the write pulse, plays Busy low for d cycles then high for h,
    // and checks grant, latched data, Ack timing/value and the sticky error.
    task automatic serve(input string nm, input int d, input int h, input int exp_gid,
                         input logic [DW-1:0] exp_data, input logic [DW-1:0] exp_mask,
                         input int exp_lat, input logic to_pre, input logic exp_to);
        bit got;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            tick();
            if (bus.IO_WrEn) got = 1'b1;
        end
        chk({nm, ".wren_seen"}, 64'(got), 64'd1);
        if (!got) return;
        chk({nm, ".gid"}, 64'(bus.Grant_Id), 64'(exp_gid));
        chk({nm, ".wdata"}, 64'(bus.IO_WrData), 64'(exp_data));
        chk({nm, ".wmask"}, 64'(bus.IO_WrMask), 64'(exp_mask));
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            busy = (k > d) && (k <= d + h);
            tick();
            if (bus.Req_Ack != '0) begin
                got = 1'b1;
                chk({nm, ".latency"}, 64'(k), 64'(exp_lat));
                chk({nm, ".ack"}, 64'(bus.Req_Ack), 64'(4'b0001 << exp_gid));
                chk({nm, ".gid_at_ack"}, 64'(bus.Grant_Id), 64'(exp_gid));
                chk({nm, ".terr"}, 64'(bus.Timeout_Err), 64'(exp_to));
                chk({nm, ".wdata_hold"}, 64'(bus.IO_WrData), 64'(exp_data));
                req_v = req_v & ~bus.Req_Ack;
            end else begin
                chk({nm, ".wren_single"}, 64'(bus.IO_WrEn), 64'd0);
                chk({nm, ".terr_pre"}, 64'(bus.Timeout_Err), 64'(to_pre));
            end
        end
        busy = 1'b0;
        chk({nm, ".ack_seen"}, 64'(got), 64'd1);
        tick();
        chk({nm, ".ack_one_cycle"}, 64'(bus.Req_Ack), 64'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req_v = '0;
        busy  = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rdata[i] = '0;
            rmask[i] = '0;
        end
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Randomized-phase model state
    int            mptr;
    bit            active;
    int            cur;
    int            rd;
    int            rh;
    int            t0;
    int            due;
    int            last_ack;
    int            win;
    int            kk;
    bit            exp_wr;
    logic [NR-1:0] exp_ack;

    initial begin
        vecs[0] = '{idx: 0, data: 32'hDEADBEEF, mask: 32'hFFFF0000, d: 0, h: 2, exp_gid: 0, exp_lat: 3};
        vecs[1] = '{idx: 2, data: 32'h12345678, mask: 32'h0000FFFF, d: 1, h: 1, exp_gid: 2, exp_lat: 3};
        vecs[2] = '{idx: 1, data: 32'hA5A5A5A5, mask: 32'hF0F0F0F0, d: 0, h: 1, exp_gid: 1, exp_lat: 2};
        vecs[3] = '{idx: 3, data: 32'h0F0F0F0F, mask: 32'hFFFFFFFF, d: 3, h: 2, exp_gid: 3, exp_lat: 6};

        do_reset();
        check_idle_outputs("reset");

        // Table: one requester at a time, other slots hold decoy data.
        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < NR; j++) begin
                rdata[j] = 32'hBAD00000 | 32'(j);
                rmask[j] = 32'h0BAD0000 | 32'(j);
            end
            rdata[vecs[v].idx] = vecs[v].data;
            rmask[vecs[v].idx] = vecs[v].mask;
            req_v = '0;
            req_v[vecs[v].idx] = 1'b1;
            serve($sformatf("vec%0d", v), vecs[v].d, vecs[v].h, vecs[v].exp_gid,
                  vecs[v].data, vecs[v].mask, vecs[v].exp_lat, 1'b0, 1'b0);
        end

        // Round-robin: all four requesting, pointer back at 0.
        for (int j = 0; j < NR; j++) begin
            rdata[j] = 32'h11110000 + 32'(j);
            rmask[j] = 32'h00FF0000 + 32'(j);
        end
        req_v = 4'b1111;
        for (int j = 0; j < NR; j++)
            serve($sformatf("rr%0d", j), 0, 1, j, rdata[j], rmask[j], 2, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("rr.no_extra_wren", 64'(bus.IO_WrEn), 64'd0);
        end

        // Pointer wrap: serve 2, then 3 is ahead of 0.
        req_v = 4'b0100;
        serve("wrap.r2", 0, 1, 2, rdata[2], rmask[2], 2, 1'b0, 1'b0);
        req_v = 4'b1001;
        serve("wrap.r3", 0, 1, 3, rdata[3], rmask[3], 2, 1'b0, 1'b0);
        serve("wrap.r0", 0, 1, 0, rdata[0], rmask[0], 2, 1'b0, 1'b0);

        // Busy already high in IDLE blocks the issue.
        busy  = 1'b1;
        req_v = 4'b0010;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("busypre.no_wren", 64'(bus.IO_WrEn), 64'd0);
        end
        busy = 1'b0;
        serve("busypre", 0, 1, 1, rdata[1], rmask[1], 2, 1'b0, 1'b0);

        // Timeout: Busy never rises; WAIT_RISE lasts BUSY_TIMEOUT cycles.
        req_v = 4'b0001;
        serve("timeout", 1000, 0, 0, rdata[0], rmask[0], TO + 1, 1'b0, 1'b1);
        req_v = 4'b0100;
        serve("after_to", 0, 2, 2, rdata[2], rmask[2], 3, 1'b1, 1'b1);

        // Reset while waiting for Busy to fall; Busy drops on the same edge.
        rdata[3] = 32'hCAFEF00D;
        req_v    = 4'b1000;
        tick();
        chk("rst.wren", 64'(bus.IO_WrEn), 64'd1);
        chk("rst.gid", 64'(bus.Grant_Id), 64'd3);
        busy = 1'b1;
        tick();
        tick();
        busy  = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_idle_outputs("rst_mid");
        rdata[0] = 32'h00C0FFEE;
        req_v    = 4'b1001;
        serve("rst.next0", 0, 1, 0, rdata[0], rmask[0], 2, 1'b0, 1'b0);
        serve("rst.next3", 0, 1, 3, rdata[3], rmask[3], 2, 1'b0, 1'b0);

        // Randomized run against the round-robin model.
        do_reset();
        mptr     = 0;
        active   = 1'b0;
        cur      = 0;
        rd       = 0;
        rh       = 0;
        t0       = 0;
        due      = 0;
        last_ack = cyc - 2;
        for (int n = 0; n < 3000; n++) begin
            tick();
            exp_wr = !active && (cyc >= last_ack + 2) && (req_v != '0) && !busy;
            chk("rnd.wren", 64'(bus.IO_WrEn), 64'(exp_wr));
            if (exp_wr) begin
                win = mptr;
                while (!req_v[win]) win = (win + 1) % NR;
                chk("rnd.gid", 64'(bus.Grant_Id), 64'(win));
                chk("rnd.wdata", 64'(bus.IO_WrData), 64'(rdata[win]));
                chk("rnd.wmask", 64'(bus.IO_WrMask), 64'(rmask[win]));
                active = 1'b1;
                cur    = win;
                rd     = int'($urandom_range(0, 3));
                rh     = int'($urandom_range(1, 3));
                t0     = cyc;
                due    = cyc + rd + rh + 1;
            end
            exp_ack = (active && cyc == due) ? (4'b0001 << cur) : 4'b0000;
            chk("rnd.ack", 64'(bus.Req_Ack), 64'(exp_ack));
            if (exp_ack != '0) begin
                req_v[cur] = 1'b0;
                active     = 1'b0;
                mptr       = (cur + 1) % NR;
                last_ack   = cyc;
            end
            kk   = cyc - t0 + 1;
            busy = active && (kk > rd) && (kk <= rd + rh);
            for (int i = 0; i < NR; i++) begin
                if (!req_v[i] && !exp_ack[i] && $urandom_range(0, 3) == 0) begin
                    req_v[i] = 1'b1;
                    rdata[i] = $urandom;
                    rmask[i] = $urandom;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
